bpc_stream_fifo: RTL and testbench

//  Synchronous valid/ready FIFO for encoder-to-packer bit-plane streams. Generalises the

---
 rtl/bpc_stream_fifo.sv | 126 ++++++++++++
 tb/tb_bpc_stream_fifo.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bpc_stream_fifo.sv
// Valid/ready FIFO between the bit-plane encoder and the packer. It has programmable
// almost-full/almost-empty levels, occupancy and peak statistics, sticky overflow, flush and an optional head register.
module bpc_stream_fifo #(
    parameter int BITWIDTH       = 64,
    parameter int STAGE          = 32,
    parameter int STAGE_BITWIDTH = $clog2(STAGE),
    parameter int OUT_REG        = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear_i,
    input  logic [BITWIDTH-1:0]       s_data_i,
    input  logic                      s_valid_i,
    output logic                      s_ready_o,
    output logic [BITWIDTH-1:0]       m_data_o,
    output logic                      m_valid_o,
    input  logic                      m_ready_i,
    input  logic [STAGE_BITWIDTH:0]   af_level_i,
    input  logic [STAGE_BITWIDTH:0]   ae_level_i,
    output logic [STAGE_BITWIDTH:0]   count_o,
    output logic [STAGE_BITWIDTH:0]   peak_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic                      almost_full_o,
    output logic                      almost_empty_o,
    output logic                      overflow_o,
    input  logic                      stat_clr_i
);
    localparam int PW = STAGE_BITWIDTH + 1;
    localparam logic [PW-1:0] CAP = PW'(STAGE + OUT_REG);

    logic [BITWIDTH-1:0] mem_q [STAGE];
    logic [PW-1:0]       wptr_q, wptr_d;
    logic [PW-1:0]       rptr_q, rptr_d;
    logic [PW-1:0]       count_q, count_d;
    logic [PW-1:0]       peak_q, peak_d;
    logic                overflow_q, overflow_d;
    logic                wr_fire, rd_fire, mem_pop;
    logic [BITWIDTH-1:0] mem_rdata;

    assign count_o        = count_q;
    assign peak_o         = peak_q;
    assign overflow_o     = overflow_q;
    assign full_o         = (count_q == CAP);
    assign empty_o        = (count_q == '0);
    assign almost_full_o  = (count_q >= af_level_i);
    assign almost_empty_o = (count_q <= ae_level_i);
    assign s_ready_o      = ~full_o;

    // Flush dominates: handshakes in a clear cycle must not move any state.
    assign wr_fire   = s_valid_i & s_ready_o & ~clear_i;
    assign rd_fire   = m_valid_o & m_ready_i & ~clear_i;
    assign mem_rdata = mem_q[rptr_q[STAGE_BITWIDTH-1:0]];

    generate
        if (OUT_REG == 0) begin : g_comb_out
            assign m_data_o  = mem_rdata;
            assign m_valid_o = ~empty_o;
            assign mem_pop   = rd_fire;
        end else begin : g_reg_out
            logic                head_valid_q, head_valid_d;
            logic [BITWIDTH-1:0] head_data_q;
            logic                mem_nonempty;

            assign mem_nonempty = (wptr_q != rptr_q);
            // Refill whenever the head slot is free or being consumed this cycle.
            assign mem_pop      = mem_nonempty & (~head_valid_q | rd_fire) & ~clear_i;
            assign m_data_o     = head_data_q;
            assign m_valid_o    = head_valid_q;

            always_comb begin
                head_valid_d = head_valid_q;
                if (clear_i)      head_valid_d = 1'b0;
                else if (mem_pop) head_valid_d = 1'b1;
                else if (rd_fire) head_valid_d = 1'b0;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) head_valid_q <= 1'b0;
                else        head_valid_q <= head_valid_d;
            end

            always_ff @(posedge clk) begin
                if (mem_pop) head_data_q <= mem_rdata;
            end
        end
    endgenerate

    always_comb begin
        wptr_d     = wptr_q + PW'(wr_fire);
        rptr_d     = rptr_q + PW'(mem_pop);
        count_d    = count_q;
        if (wr_fire && !rd_fire)      count_d = count_q + PW'(1);
        else if (!wr_fire && rd_fire) count_d = count_q - PW'(1);
        if (clear_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end
        overflow_d = (s_valid_i & full_o) | (overflow_q & ~stat_clr_i);
        if (stat_clr_i)           peak_d = count_d;
        else if (count_d > peak_q) peak_d = count_d;
        else                       peak_d = peak_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            peak_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            peak_q     <= peak_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) mem_q[wptr_q[STAGE_BITWIDTH-1:0]] <= s_data_i;
    end

endmodule

// File: tb/tb_bpc_stream_fifo.sv
// Directed bench for bpc_stream_fifo: one instance with a combinational head, one with a registered head.
module tb_bpc_stream_fifo;
    localparam int BW = 64;
    localparam int ST = 32;
    localparam int PW = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          clr0, s0_valid, s0_ready, m0_valid, m0_ready, full0, empty0, afl0, ael0, ovf0, sclr0;
    logic [BW-1:0] s0_data, m0_data;
    logic [PW-1:0] af0, ae0, count0, peak0;
    logic          clr1, s1_valid, s1_ready, m1_valid, m1_ready, full1, empty1, afl1, ael1, ovf1, sclr1;
    logic [BW-1:0] s1_data, m1_data;
    logic [PW-1:0] af1, ae1, count1, peak1;

    bpc_stream_fifo #(.BITWIDTH(BW), .STAGE(ST), .OUT_REG(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .clear_i(clr0),
        .s_data_i(s0_data), .s_valid_i(s0_valid), .s_ready_o(s0_ready),
        .m_data_o(m0_data), .m_valid_o(m0_valid), .m_ready_i(m0_ready),
        .af_level_i(af0), .ae_level_i(ae0), .count_o(count0), .peak_o(peak0),
        .full_o(full0), .empty_o(empty0), .almost_full_o(afl0), .almost_empty_o(ael0),
        .overflow_o(ovf0), .stat_clr_i(sclr0)
    );

    bpc_stream_fifo #(.BITWIDTH(BW), .STAGE(ST), .OUT_REG(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .clear_i(clr1),
        .s_data_i(s1_data), .s_valid_i(s1_valid), .s_ready_o(s1_ready),
        .m_data_o(m1_data), .m_valid_o(m1_valid), .m_ready_i(m1_ready),
        .af_level_i(af1), .ae_level_i(ae1), .count_o(count1), .peak_o(peak1),
        .full_o(full1), .empty_o(empty1), .almost_full_o(afl1), .almost_empty_o(ael1),
        .overflow_o(ovf1), .stat_clr_i(sclr1)
    );

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int  acc, sent, rcvd, q, maxq, cyc, cnt_err;
        logic wr, rd;

        clr0 = 0; s0_valid = 0; s0_data = '0; m0_ready = 0; sclr0 = 0; af0 = 6'd30; ae0 = 6'd2;
        clr1 = 0; s1_valid = 0; s1_data = '0; m1_ready = 0; sclr1 = 0; af1 = 6'd40; ae1 = 6'd0;

        // Reset state
        #12;
        check("rst_count",   count0, 0);
        check("rst_s_ready", s0_ready, 1);
        check("rst_empty",   empty0, 1);
        check("rst_m_valid", m0_valid, 0);
        check("rst_ae",      ael0, 1);
        check("rst_full",    full0, 0);
        check("rst_ovf",     ovf0, 0);
        check("rst_peak",    peak0, 0);
        check("rst_m_valid1", m1_valid, 0);
        rst_n = 1'b1;
        step();

        // T1: combinational head latency
        s0_valid = 1; s0_data = 64'hA5;
        #1 check("t1_pre_valid", m0_valid, 0);
        step(); s0_valid = 0;
        check("t1_valid", m0_valid, 1);
        check("t1_data",  m0_data, 64'hA5);
        check("t1_count", count0, 1);
        check("t1_empty", empty0, 0);

        // T2: registered head latency and stall
        s1_valid = 1; s1_data = 64'hA5;
        step(); s1_valid = 0;
        check("t2_valid_c1", m1_valid, 0);
        check("t2_count_c1", count1, 1);
        step();
        check("t2_valid_c2", m1_valid, 1);
        check("t2_data_c2",  m1_data, 64'hA5);
        check("t2_count_c2", count1, 1);
        s1_valid = 1; s1_data = 64'hB6;
        step(); s1_valid = 0;
        step(); step();
        check("t2_hold_data", m1_data, 64'hA5);
        check("t2_count2",    count1, 2);
        m1_ready = 1;
        step();
        check("t2_next_data", m1_data, 64'hB6);
        check("t2_count_rd",  count1, 1);
        step();
        check("t2_drained_valid", m1_valid, 0);
        check("t2_drained_empty", empty1, 1);

        // Registered head: capacity STAGE+1, then back-to-back drain
        m1_ready = 0; acc = 0;
        for (int i = 0; i < 40; i++) begin
            s1_valid = 1; s1_data = 64'h300 + 64'(acc);
            #1 wr = s1_ready;
            step();
            if (wr) acc++;
        end
        s1_valid = 0;
        check("t2_cap_accepted", 64'(acc), 33);
        check("t2_cap_count",    count1, 33);
        check("t2_cap_full",     full1, 1);
        check("t2_cap_ovf",      ovf1, 1);
        m1_ready = 1;
        for (int i = 0; i < 33; i++) begin
            check("t2_stream_valid", m1_valid, 1);
            check("t2_stream_data",  m1_data, 64'h300 + 64'(i));
            step();
        end
        m1_ready = 0;
        check("t2_stream_empty", empty1, 1);

        // T3: fill with almost levels
        m0_ready = 1; step(); m0_ready = 0;
        check("t3_start_count", count0, 0);
        for (int k = 1; k <= 32; k++) begin
            s0_valid = 1; s0_data = 64'h100 + 64'(k - 1);
            step();
            if (k == 2)  check("t3_ae_at2",  ael0, 1);
            if (k == 3)  check("t3_ae_at3",  ael0, 0);
            if (k == 29) check("t3_af_at29", afl0, 0);
            if (k == 30) check("t3_af_at30", afl0, 1);
            if (k == 31) check("t3_full_at31", full0, 0);
        end
        s0_valid = 0;
        check("t3_full",    full0, 1);
        check("t3_s_ready", s0_ready, 0);
        check("t3_count",   count0, 32);
        check("t3_ovf_pre", ovf0, 0);
        s0_valid = 1; s0_data = 64'hDEAD;
        step(); s0_valid = 0;
        check("t3_ovf",   ovf0, 1);
        check("t3_count_after_ovf", count0, 32);
        check("t3_peak",  peak0, 32);

        // T5: set beats clear; clear loads peak with live count
        s0_valid = 1; sclr0 = 1;
        step(); s0_valid = 0;
        check("t5_set_wins", ovf0, 1);
        step(); sclr0 = 0;
        check("t5_ovf_clr",  ovf0, 0);
        check("t5_peak_clr", peak0, 32);
        m0_ready = 1;
        for (int i = 0; i < 27; i++) begin
            check("t5_drain_data", m0_data, 64'h100 + 64'(i));
            step();
        end
        m0_ready = 0;
        check("t5_count5", count0, 5);
        sclr0 = 1; step(); sclr0 = 0;
        check("t5_peak_reload", peak0, 5);
        s0_valid = 1; s0_data = 64'h200; m0_ready = 1;
        #1 check("t5_head_before", m0_data, 64'h11B);
        step(); s0_valid = 0; m0_ready = 0;
        check("t5_simul_count", count0, 5);
        check("t5_simul_head",  m0_data, 64'h11C);
        for (int i = 1; i <= 5; i++) begin
            s0_valid = 1; s0_data = 64'h200 + 64'(i);
            step();
        end
        s0_valid = 0;
        check("t6_count10", count0, 10);
        check("t6_peak10",  peak0, 10);

        // T6: flush with concurrent write and read
        clr0 = 1; s0_valid = 1; s0_data = 64'hBAD; m0_ready = 1;
        step(); clr0 = 0; s0_valid = 0; m0_ready = 0;
        check("t6_flush_count", count0, 0);
        check("t6_flush_valid", m0_valid, 0);
        check("t6_flush_empty", empty0, 1);
        check("t6_flush_peak",  peak0, 10);
        check("t6_flush_ovf",   ovf0, 0);
        s0_valid = 1; s0_data = 64'h77;
        step(); s0_valid = 0;
        check("t6_post_data",  m0_data, 64'h77);
        check("t6_post_count", count0, 1);
        m0_ready = 1; step(); m0_ready = 0;

        // T4: 100-word stream with random backpressure
        sclr0 = 1; step(); sclr0 = 0;
        check("t4_peak_zero", peak0, 0);
        sent = 0; rcvd = 0; q = 0; maxq = 0; cyc = 0; cnt_err = 0;
        while (rcvd < 100 && cyc < 3000) begin
            s0_valid = (sent < 100); s0_data = 64'(sent);
            m0_ready = 1'($urandom_range(0, 1));
            #1;
            wr = s0_valid & s0_ready;
            rd = m0_valid & m0_ready;
            if (rd) check("t4_data", m0_data, 64'(rcvd));
            step();
            if (wr) begin sent++; q++; end
            if (rd) begin rcvd++; q--; end
            if (q > maxq) maxq = q;
            if (int'(count0) != q) cnt_err++;
            cyc++;
        end
        s0_valid = 0; m0_ready = 0;
        check("t4_received", 64'(rcvd), 100);
        check("t4_count_track", 64'(cnt_err), 0);
        check("t4_peak", peak0, 64'(maxq));
        check("t4_empty", empty0, 1);

        // T6: asynchronous reset mid-stream
        for (int i = 0; i < 3; i++) begin
            s0_valid = 1; s0_data = 64'h500 + 64'(i);
            s1_valid = 1; s1_data = 64'h600 + 64'(i);
            step();
        end
        check("t6_pre_rst_count", count0, 3);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("t6_arst_count",   count0, 0);
        check("t6_arst_valid",   m0_valid, 0);
        check("t6_arst_s_ready", s0_ready, 1);
        check("t6_arst_empty",   empty0, 1);
        check("t6_arst_ae",      ael0, 1);
        check("t6_arst_peak",    peak0, 0);
        check("t6_arst_count1",  count1, 0);
        check("t6_arst_valid1",  m1_valid, 0);
        check("t6_arst_ovf1",    ovf1, 0);
        s0_valid = 0; s1_valid = 0;
        #10 rst_n = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
